// File: rtl/weight_fetcher.sv
// weight_fetcher: reads a run of weight rows from BRAM and streams them to the
// weight FIFO through a 2-entry prefetch buffer. Rev 1.0
`default_nettype none

module weight_fetcher #(
  parameter int LANES  = 32,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  input  logic [CNT_W-1:0]              num_rows_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          mem_rd_en_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  input  logic [LANES-1:0][DATA_W-1:0]  mem_data_i,
  output logic                          write_en_o,
  output logic                          sending_data_o,
  output logic [LANES-1:0][DATA_W-1:0]  data_o,
  input  logic                          request_data_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic                                busy_q, done_q;
  logic [ADDR_W-1:0]                   base_q;
  logic [CNT_W-1:0]                    num_q, issued_q, sent_q;
  logic [1:0][LANES-1:0][DATA_W-1:0]   rowbuf_q;
  logic                                wr_ptr_q, rd_ptr_q;
  logic [1:0]                          count_q;
  logic                                inflight_q;

  logic                                pop_d;
  logic                                rd_en_d;
  logic [2:0]                          occ_after_d;

  assign sending_data_o = (count_q != 2'd0);
  assign data_o         = rowbuf_q[rd_ptr_q];
  assign pop_d          = sending_data_o & request_data_i;

  // A read may issue only if its returning row is guaranteed a free slot.
  assign occ_after_d = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_d};
  assign rd_en_d     = (state_q == S_STREAM) && (issued_q < num_q) && (occ_after_d < 3'd2);

  assign mem_rd_en_o = rd_en_d;
  assign mem_addr_o  = base_q + ADDR_W'(issued_q);
  assign busy_o      = busy_q;
  assign write_en_o  = busy_q;
  assign done_o      = done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (num_rows_i != '0) ? S_STREAM : S_DONE;
        end
      end
      S_STREAM: begin
        if (pop_d && (sent_q == num_q - CNT_W'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      rowbuf_q   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d == S_STREAM);
      done_q     <= (state_d == S_DONE);
      inflight_q <= rd_en_d;
      count_q    <= count_q + {1'b0, inflight_q} - {1'b0, pop_d};

      if (state_q == S_IDLE && start_i) begin
        base_q   <= base_addr_i;
        num_q    <= num_rows_i;
        issued_q <= '0;
        sent_q   <= '0;
      end
      if (rd_en_d) begin
        issued_q <= issued_q + CNT_W'(1);
      end
      if (inflight_q) begin
        rowbuf_q[wr_ptr_q] <= mem_data_i;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop_d) begin
        sent_q   <= sent_q + CNT_W'(1);
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_weight_fetcher.sv
// tb_weight_fetcher: randomized scoreboard bench for weight_fetcher. Rev 1.0
`default_nettype none

module tb_weight_fetcher;
  localparam int LANES  = 32;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;
  localparam int RW     = LANES * DATA_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [RW-1:0] row_t;

  logic              clk, rst_i, start_i, request_data_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [CNT_W-1:0]  num_rows_i;
  logic              busy_o, done_o, mem_rd_en_o, write_en_o, sending_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  row_t              mem_rdata, data_o;

  weight_fetcher #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_rows_i(num_rows_i), .busy_o(busy_o), .done_o(done_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_rdata),
    .write_en_o(write_en_o), .sending_data_o(sending_data_o), .data_o(data_o),
    .request_data_i(request_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  row_t mem [0:DEPTH-1];
  always @(posedge clk) if (mem_rd_en_o) mem_rdata <= mem[mem_addr_o];

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc++;

  row_t              exp_data[$];
  logic [ADDR_W-1:0] exp_addr[$];
  int rd_cnt = 0, xfer_cnt = 0, done_cnt = 0;
  int first_rd = -1, first_send = -1, done_cyc = -1, zero_viol = 0;
  bit zero_mode = 0, prev_stall = 0;
  row_t prev_data;
  int req_mode = 0, req_ph = 0;

  task automatic chk_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_row(input string nm, input row_t act, input row_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a transfer seen here happens on the following rising edge.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (prev_stall && sending_data_o) chk_row("stall_stable", data_o, prev_data);
      prev_stall = sending_data_o && !request_data_i;
      prev_data  = data_o;
      if (sending_data_o && request_data_i) begin
        xfer_cnt++;
        if (first_send < 0) first_send = cyc;
        if (exp_data.size() == 0) chk_int("unexpected_transfer", 1, 0);
        else chk_row("xfer_data", data_o, exp_data.pop_front());
      end
      if (mem_rd_en_o) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        if (exp_addr.size() == 0) chk_int("unexpected_read", 1, 0);
        else chk_int("rd_addr", int'(mem_addr_o), int'(exp_addr.pop_front()));
        chk_int("outstanding_le2", int'((rd_cnt - xfer_cnt) <= 2), 1);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        chk_int("busy_at_done", int'(busy_o), 0);
        chk_int("wen_at_done", int'(write_en_o), 0);
      end
      if (zero_mode && (mem_rd_en_o || sending_data_o || write_en_o)) zero_viol++;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    request_data_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (req_mode)
        0: request_data_i = 1'b1;
        1: begin request_data_i = (req_ph == 0); req_ph = (req_ph + 1) % 3; end
        default: request_data_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic push_run(input int b, input int n);
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(ADDR_W'((b + k) % DEPTH));
      exp_data.push_back(mem[(b + k) % DEPTH]);
    end
  endtask

  task automatic run_cmd(input int b, input int n, input int mode, input bit inject);
    int t0, dc0, xc0;
    req_mode = mode; req_ph = 0;
    dc0 = done_cnt; xc0 = xfer_cnt;
    first_rd = -1; first_send = -1; done_cyc = -1;
    zero_mode = (n == 0); zero_viol = 0;
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = ADDR_W'(b); num_rows_i = CNT_W'(n); t0 = cyc;
    push_run(b, n);
    @(posedge clk); #1;
    start_i = 1'b0;
    if (inject) begin
      repeat (2) @(posedge clk);
      #1;
      start_i = 1'b1; base_addr_i = ADDR_W'(b + 100); num_rows_i = CNT_W'(n + 3);
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    for (int i = 0; i < 400 && done_cnt == dc0; i++) @(posedge clk);
    if (done_cnt == dc0) chk_int("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    chk_int("done_count", done_cnt - dc0, 1);
    chk_int("xfer_count", xfer_cnt - xc0, n);
    chk_int("data_q_empty", exp_data.size(), 0);
    chk_int("addr_q_empty", exp_addr.size(), 0);
    if (mode == 0) begin
      chk_int("done_latency", done_cyc - t0, (n == 0) ? 1 : n + 3);
      if (n > 0) begin
        chk_int("first_rd_latency", first_rd - t0, 1);
        chk_int("first_send_latency", first_send - t0, 3);
      end
    end
    if (n == 0) begin
      chk_int("zero_no_activity", zero_viol, 0);
      chk_int("zero_no_read", first_rd, -1);
    end
    zero_mode = 0;
    exp_data.delete(); exp_addr.delete();
    rd_cnt = xfer_cnt;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_int({tag, "_busy"}, int'(busy_o), 0);
    chk_int({tag, "_done"}, int'(done_o), 0);
    chk_int({tag, "_rd_en"}, int'(mem_rd_en_o), 0);
    chk_int({tag, "_addr"}, int'(mem_addr_o), 0);
    chk_int({tag, "_wen"}, int'(write_en_o), 0);
    chk_int({tag, "_sending"}, int'(sending_data_o), 0);
    chk_row({tag, "_data"}, data_o, '0);
  endtask

  initial begin
    int dc0, xc0, b;
    row_t r;
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_rows_i = '0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int j = 0; j < LANES; j++) r[j*DATA_W +: DATA_W] = DATA_W'($urandom);
      mem[a] = r;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;

    run_cmd(32'h010, 4, 0, 0);
    run_cmd(int'($urandom_range(0, DEPTH - 1)), 6, 1, 0);
    run_cmd(32'h123, 0, 0, 0);
    run_cmd(32'h3FE, 4, 0, 0);
    run_cmd(32'h200, 6, 2, 1);

    // Abort a run partway, then confirm a fresh run is complete and correct.
    req_mode = 0;
    dc0 = done_cnt; xc0 = xfer_cnt;
    b = 32'h2C0;
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = ADDR_W'(b); num_rows_i = CNT_W'(8);
    push_run(b, 8);
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 100 && (xfer_cnt - xc0) < 2; i++) @(posedge clk);
    chk_int("pre_reset_xfers", int'((xfer_cnt - xc0) >= 2), 1);
    #1;
    rst_i = 1'b1;
    exp_data.delete(); exp_addr.delete();
    @(posedge clk); #1;
    rst_i = 1'b0;
    rd_cnt = xfer_cnt;
    check_reset_outputs("midop_reset");
    repeat (20) @(posedge clk);
    chk_int("no_done_after_reset", done_cnt - dc0, 0);
    run_cmd(32'h0F0, 8, 0, 0);

    for (int t = 0; t < 4; t++) begin
      run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 2, 0);
    end
    run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 20)), 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/weight_fetcher.md
Name: weight_fetcher

Overview:
Producer side of the weight-FIFO load interface. On a start command it reads a run of 32-byte weight rows from the on-chip weight BRAM (1-cycle read latency) and streams them to the weight FIFO. It uses the FIFO's write_en/request/sending handshake and a 2-entry prefetch buffer so the stream sustains one row per cycle. It sits between the weight memory and the weight FIFO feeding the systolic array.

Parameters:
LANES, 32, row width in bytes (one byte per array column)
DATA_W, 8, bits per weight
ADDR_W, 10, BRAM row address width
CNT_W, 8, width of row-count field (max 2^CNT_W-1 rows per command)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
start_i  in  1  command strobe; accepted only in IDLE
base_addr_i  in  ADDR_W  first BRAM row of the run
num_rows_i  in  CNT_W  number of rows to send; 0 is legal
busy_o  out  1  command in progress
done_o  out  1  one-cycle pulse after last row transferred
mem_rd_en_o  out  1  BRAM read enable
mem_addr_o  out  ADDR_W  BRAM read address
mem_data_i  in  DATA_W x LANES  BRAM row, valid the cycle after mem_rd_en_o
write_en_o  out  1  session active toward FIFO (FIFO write_en_i)
sending_data_o  out  1  data_o holds a valid row (FIFO sending_data_i)
data_o  out  DATA_W x LANES  row presented to FIFO (FIFO data_i)
request_data_i  in  1  FIFO can accept this cycle (FIFO request_data_o = write_en & ~full)

Behaviour:
- Clock and reset: one clock, synchronous active-high reset. Reset values: busy_o=0, done_o=0, mem_rd_en_o=0, mem_addr_o=0, write_en_o=0, sending_data_o=0, data_o=all 0. Reset also empties the buffer, clears the in-flight flag and counters, and sets state to IDLE.
- States are IDLE, STREAM and DONE.
- IDLE:
  - start_i=1 and num_rows_i>0: latch base_addr_i and num_rows_i, go to STREAM.
  - start_i=1 and num_rows_i=0: go to DONE. No memory reads.
  - start_i=0: stay in IDLE.
- STREAM: busy_o=1, write_en_o=1.
- DONE: lasts one cycle. done_o=1, busy_o=0, write_en_o=0, then return to IDLE. start_i is ignored in DONE. The earliest accepted restart is the cycle after done_o.
- start_i while busy is ignored; latched parameters are unchanged.
- Transfer occurs in a cycle when request_data_i=1 and sending_data_o=1. This is the same condition the FIFO uses to write.
- sending_data_o = buffer not empty. data_o = buffer head. The head is held stable until transferred.
- Read issue: mem_rd_en_o=1 when issued<num_rows and (occupancy + in_flight - pop) < 2, where pop is a transfer this cycle. This guarantees the returning row always has a buffer slot. There is no combinational path from mem_data_i to outputs.
- mem_addr_o = base + issued, modulo 2^ADDR_W (wraps from 2^ADDR_W-1 to 0). issued increments on each read.
- Returned data is written into the buffer one cycle after mem_rd_en_o. Order is preserved: row k comes from address base+k.
- Simultaneous push and pop on the buffer leaves occupancy unchanged.
- Latency: start accepted at cycle T → first mem_rd_en_o at T+1 → first sending_data_o=1 at T+3.
- Throughput: with request_data_i held at 1, one transfer per cycle from T+3 until the last row.
- Termination: on the cycle of the N-th transfer, the next state is DONE.
- Backpressure: request_data_i=0 stalls transfers. At most 2 rows are buffered or in flight. sending_data_o and data_o stay stable.
- Reset mid-command: abandon immediately, drop buffered rows, no done_o.

Test Plan:
- Streaming: base=0x010, N=4, request_data_i=1 throughout → mem_addr 0x010..0x013 on T+1..T+4; transfers at T+3..T+6 with data equal to BRAM rows 0x010..0x013; done_o=1 at T+7 only; busy_o low at T+7.
- Backpressure: N=6, request_data_i toggles 1,0,0,1,... → exactly 6 transfers in address order; no row lost or duplicated; data_o stable whenever sending=1 and request=0; never more than 2 reads outstanding plus buffered.
- Zero rows: start with N=0 → done_o pulses at T+1; mem_rd_en_o, sending_data_o and write_en_o remain 0.
- Address wrap: base=0x3FE, N=4 (ADDR_W=10) → reads from 0x3FE, 0x3FF, 0x000, 0x001; data in that order.
- Start while busy: second start_i with different base during STREAM → ignored; only the original N rows are sent; one done_o.
- Reset mid-op: assert rst_i after 2 of 8 transfers → the next cycle shows all outputs at reset values; a new start then sends the full new run correctly.
